// File: rtl/delay_ctrl_pkg.sv
// Shared types and constants for the delay_ctrl edge-delay controller.
package delay_ctrl_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    PEND_RISE = 2'd1,
    HIGH      = 2'd2,
    PEND_FALL = 2'd3
  } chan_state_t;

  localparam int GLITCH_W = 8;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_ctrl_chan.sv
// One delay/filter channel: input register, 4-state FSM, delay counter, delay registers.
// Optional swallowed-transition counter under DELAY_CTRL_GLITCH_COUNT_EN.
module delay_ctrl_chan
  import delay_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RISE_DEFAULT = '0,
  parameter logic [WIDTH-1:0] FALL_DEFAULT = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_rise,
  input  logic [WIDTH-1:0]    load_fall,
  output logic                dout,
  output logic                busy,
  output logic                stable,
  output logic [GLITCH_W-1:0] glitch_cnt,
  output chan_state_t         state
);

  chan_state_t      state_q, state_d;
  logic             din_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW;
      din_q   <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= RISE_DEFAULT;
      fall_q  <= FALL_DEFAULT;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

  // Counter starts at 1 on entry so cnt==delay marks D+1 consecutive samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOW: if (din_q) begin
        if (rise_q == '0) state_d = HIGH;
        else begin
          state_d = PEND_RISE;
          cnt_d   = WIDTH'(1);
        end
      end
      PEND_RISE: begin
        if (!din_q)               state_d = LOW;
        else if (cnt_q == rise_q) state_d = HIGH;
        else                      cnt_d   = cnt_q + WIDTH'(1);
      end
      HIGH: if (!din_q) begin
        if (fall_q == '0) state_d = LOW;
        else begin
          state_d = PEND_FALL;
          cnt_d   = WIDTH'(1);
        end
      end
      PEND_FALL: begin
        if (din_q)                state_d = HIGH;
        else if (cnt_q == fall_q) state_d = LOW;
        else                      cnt_d   = cnt_q + WIDTH'(1);
      end
      default: state_d = LOW;
    endcase
  end

  // Outputs are registered from the current state, one edge behind the FSM.
  always_comb begin
    dout_d = (state_q == HIGH) || (state_q == PEND_FALL);
    busy_d = (state_q == PEND_RISE) || (state_q == PEND_FALL);
    stable = ((state_q == LOW) && !din_q) || ((state_q == HIGH) && din_q);
    rise_d = load ? load_rise : rise_q;
    fall_d = load ? load_fall : fall_q;
  end

  assign dout  = dout_q;
  assign busy  = busy_q;
  assign state = state_q;

`ifdef DELAY_CTRL_GLITCH_COUNT_EN
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                glitch_ev;

  always_comb begin
    glitch_ev = ((state_q == PEND_RISE) && !din_q) || ((state_q == PEND_FALL) && din_q);
    glitch_d  = glitch_q;
    if (glitch_ev && (glitch_q != {GLITCH_W{1'b1}})) glitch_d = glitch_q + GLITCH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) glitch_q <= '0;
    else     glitch_q <= glitch_d;
  end

  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = '0;
`endif

endmodule

// File: rtl/delay_ctrl.sv
// Multi-channel runtime-configurable edge-delay controller: shared config shadow slot,
// valid/ready handshake, address decode, cfg_err. Optional macro: DELAY_CTRL_GLITCH_COUNT_EN.
module delay_ctrl
  import delay_ctrl_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RISE_DEFAULT = '0,
  parameter logic [WIDTH-1:0] FALL_DEFAULT = '0,
  localparam int AW = addr_width(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          din,
  output logic [CHANNELS-1:0]          dout,
  output logic [CHANNELS-1:0]          busy,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [AW-1:0]                cfg_addr,
  input  logic [WIDTH-1:0]             cfg_rise,
  input  logic [WIDTH-1:0]             cfg_fall,
  output logic                         cfg_err,
  output logic [CHANNELS*GLITCH_W-1:0] glitch_cnt,
  output logic [2*CHANNELS-1:0]        dbg_state
);

  // Handshake: a transfer happens on a clock edge where cfg_valid && cfg_ready.
  logic             shadow_vld_q, shadow_vld_d;
  logic [AW-1:0]    shadow_addr_q, shadow_addr_d;
  logic [WIDTH-1:0] shadow_rise_q, shadow_rise_d;
  logic [WIDTH-1:0] shadow_fall_q, shadow_fall_d;
  logic             err_q, err_d;
  logic             accept, addr_ok;
  logic [CHANNELS-1:0] load, stable;

  assign cfg_ready = !rst && !shadow_vld_q;
  assign cfg_err   = err_q;

  always_comb begin
    accept  = cfg_valid && cfg_ready;
    addr_ok = 32'(cfg_addr) < 32'(CHANNELS);
    load    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      load[c] = shadow_vld_q && (shadow_addr_q == AW'(c)) && stable[c];
    end
    shadow_vld_d  = shadow_vld_q;
    shadow_addr_d = shadow_addr_q;
    shadow_rise_d = shadow_rise_q;
    shadow_fall_d = shadow_fall_q;
    // Out-of-range requests are consumed without occupying the shadow slot.
    if (accept && addr_ok) begin
      shadow_vld_d  = 1'b1;
      shadow_addr_d = cfg_addr;
      shadow_rise_d = cfg_rise;
      shadow_fall_d = cfg_fall;
    end else if (|load) begin
      shadow_vld_d = 1'b0;
    end
    err_d = accept && !addr_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_vld_q  <= 1'b0;
      shadow_addr_q <= '0;
      shadow_rise_q <= '0;
      shadow_fall_q <= '0;
      err_q         <= 1'b0;
    end else begin
      shadow_vld_q  <= shadow_vld_d;
      shadow_addr_q <= shadow_addr_d;
      shadow_rise_q <= shadow_rise_d;
      shadow_fall_q <= shadow_fall_d;
      err_q         <= err_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    chan_state_t st;
    delay_ctrl_chan #(
      .WIDTH        (WIDTH),
      .RISE_DEFAULT (RISE_DEFAULT),
      .FALL_DEFAULT (FALL_DEFAULT)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .din        (din[c]),
      .load       (load[c]),
      .load_rise  (shadow_rise_q),
      .load_fall  (shadow_fall_q),
      .dout       (dout[c]),
      .busy       (busy[c]),
      .stable     (stable[c]),
      .glitch_cnt (glitch_cnt[GLITCH_W*c +: GLITCH_W]),
      .state      (st)
    );
    assign dbg_state[2*c +: 2] = st;
  end

endmodule

// File: tb/tb_delay_ctrl.sv
// Self-checking bench for delay_ctrl: directed scenarios plus randomized din against a
// sliding-window reference model (output flips once input held the other level D+1 samples).
module tb_delay_ctrl;

  localparam int NCH = 3;  // three channels so that cfg_addr=3 is representable and out of range
  localparam int W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   din;
  logic [NCH-1:0]   dout, busy;
  logic             cfg_valid, cfg_ready, cfg_err;
  logic [1:0]       cfg_addr;
  logic [W-1:0]     cfg_rise, cfg_fall;
  logic [NCH*8-1:0] glitch_cnt;
  logic [2*NCH-1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  delay_ctrl #(
    .CHANNELS     (NCH),
    .WIDTH        (W),
    .RISE_DEFAULT (8'd0),
    .FALL_DEFAULT (8'd0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dout       (dout),
    .busy       (busy),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_rise   (cfg_rise),
    .cfg_fall   (cfg_fall),
    .cfg_err    (cfg_err),
    .glitch_cnt (glitch_cnt),
    .dbg_state  (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model and scoreboard
  logic           model_en = 1'b0;
  logic           hist [NCH][$];
  logic [NCH-1:0] exp_lvl;
  int             m_rise [NCH];
  int             m_fall [NCH];
  logic [NCH-1:0] exp_q [$];

  always @(posedge clk) begin
    if (model_en) begin
      for (int c = 0; c < NCH; c++) begin
        int   d;
        int   n;
        logic flip;
        hist[c].push_back(din[c]);
        n    = hist[c].size();
        d    = exp_lvl[c] ? m_fall[c] : m_rise[c];
        flip = 1'b1;
        // Window: the D+1 samples that ended two edges ago.
        for (int k = 0; k <= d; k++) begin
          if (hist[c][n-3-k] == exp_lvl[c]) flip = 1'b0;
        end
        if (flip) exp_lvl[c] = ~exp_lvl[c];
        if (n > 64) void'(hist[c].pop_front());
      end
      exp_q.push_back(exp_lvl);
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input int rise, input int fall);
    int n;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 100) begin tick(); n++; end
    cfg_valid = 1'b1;
    cfg_addr  = addr[1:0];
    cfg_rise  = rise[W-1:0];
    cfg_fall  = fall[W-1:0];
    tick();
    cfg_valid = 1'b0;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_apply_timeout addr=%0d: cfg_ready=%b required 1", addr, cfg_ready);
    end
  endtask

  task automatic model_start();
    exp_lvl = '0;
    for (int c = 0; c < NCH; c++) begin
      hist[c].delete();
      for (int k = 0; k < 40; k++) hist[c].push_back(1'b0);
    end
    exp_q.delete();
    model_en = 1'b1;
  endtask

  task automatic model_stop();
    model_en = 1'b0;
    din = '0;
    repeat (10) tick();
    exp_q.delete();
  endtask

  task automatic run_random(input int cycles, input bit sparse);
    logic [NCH-1:0] e;
    for (int i = 0; i < cycles; i++) begin
      if (!sparse) din = NCH'($urandom_range(0, 7));
      else for (int c = 0; c < NCH; c++) if ($urandom_range(0, 3) == 0) din[c] = ~din[c];
      tick();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rand_scoreboard_empty cycle=%0d", i);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL rand_dout cycle=%0d: dout=%b required %b", i, dout, e);
        end
      end
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst = 1'b1; din = '0; cfg_valid = 1'b0; cfg_addr = '0; cfg_rise = '0; cfg_fall = '0;
    repeat (3) tick();
    checks++; if (dout !== '0)      begin errors++; $display("FAIL reset_dout: %b required 0", dout); end
    checks++; if (busy !== '0)      begin errors++; $display("FAIL reset_busy: %b required 0", busy); end
    checks++; if (cfg_ready !== 0)  begin errors++; $display("FAIL reset_ready: %b required 0", cfg_ready); end
    checks++; if (cfg_err !== 0)    begin errors++; $display("FAIL reset_err: %b required 0", cfg_err); end
    checks++; if (glitch_cnt !== '0) begin errors++; $display("FAIL reset_glitch: %h required 0", glitch_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (cfg_ready !== 1)  begin errors++; $display("FAIL reset_release_ready: %b required 1", cfg_ready); end
  endtask

  task automatic test_rise_fall();
    logic ed, eb;
    cfg_write(0, 5, 0);
    din[0] = 1'b1;
    for (int k = 10; k <= 40; k++) begin
      tick();
      ed = (k >= 17 && k < 32);
      eb = (k >= 12 && k <= 16);
      checks++; if (dout[0] !== ed) begin errors++; $display("FAIL rise_dout edge=%0d: %b required %b", k, dout[0], ed); end
      checks++; if (busy[0] !== eb) begin errors++; $display("FAIL rise_busy edge=%0d: %b required %b", k, busy[0], eb); end
      if (k == 29) din[0] = 1'b0;
    end
  endtask

  task automatic test_glitch();
    logic eb;
    logic [7:0] eg;
    din[0] = 1'b1;
    for (int k = 10; k <= 25; k++) begin
      tick();
      eb = (k >= 12 && k <= 16);
      checks++; if (dout[0] !== 1'b0) begin errors++; $display("FAIL glitch_dout edge=%0d: %b required 0", k, dout[0]); end
      checks++; if (busy[0] !== eb)   begin errors++; $display("FAIL glitch_busy edge=%0d: %b required %b", k, busy[0], eb); end
      if (k == 14) din[0] = 1'b0;
    end
`ifdef DELAY_CTRL_GLITCH_COUNT_EN
    eg = 8'd1;
`else
    eg = 8'd0;
`endif
    checks++; if (glitch_cnt[7:0] !== eg) begin errors++; $display("FAIL glitch_cnt: %0d required %0d", glitch_cnt[7:0], eg); end
  endtask

  task automatic test_cfg_pending();
    logic er, ed, eb;
    cfg_write(1, 0, 3);
    din[1] = 1'b1;
    repeat (4) tick();
    din[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      er = (k < 2 || k >= 5);
      ed = (k < 5);
      eb = (k >= 2 && k <= 4);
      checks++; if (cfg_ready !== er) begin errors++; $display("FAIL pend_ready k=%0d: %b required %b", k, cfg_ready, er); end
      checks++; if (dout[1] !== ed)   begin errors++; $display("FAIL pend_dout k=%0d: %b required %b", k, dout[1], ed); end
      checks++; if (busy[1] !== eb)   begin errors++; $display("FAIL pend_busy k=%0d: %b required %b", k, busy[1], eb); end
      if (k == 1) begin cfg_valid = 1'b1; cfg_addr = 2'd1; cfg_rise = 8'd2; cfg_fall = 8'd2; end
      if (k == 2) cfg_valid = 1'b0;
    end
    din[1] = 1'b1;
    for (int j = 0; j < 7; j++) begin
      tick();
      ed = (j >= 4);
      checks++; if (dout[1] !== ed) begin errors++; $display("FAIL pend_newrise j=%0d: %b required %b", j, dout[1], ed); end
    end
  endtask

  task automatic test_cfg_err();
    logic e1, e2;
    cfg_valid = 1'b1; cfg_addr = 2'd3; cfg_rise = 8'd7; cfg_fall = 8'd7;
    tick();
    cfg_valid = 1'b0;
    checks++; if (cfg_err !== 1'b1)   begin errors++; $display("FAIL err_pulse: %b required 1", cfg_err); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL err_ready: %b required 1", cfg_ready); end
    tick();
    checks++; if (cfg_err !== 1'b0)   begin errors++; $display("FAIL err_pulse_end: %b required 0", cfg_err); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL err_ready2: %b required 1", cfg_ready); end
    din[1] = 1'b0;
    din[2] = 1'b1;
    for (int j = 0; j < 7; j++) begin
      tick();
      e1 = (j < 4);
      e2 = (j >= 2);
      checks++; if (dout[1] !== e1) begin errors++; $display("FAIL err_ch1_fall j=%0d: %b required %b", j, dout[1], e1); end
      checks++; if (dout[2] !== e2) begin errors++; $display("FAIL err_ch2_rise j=%0d: %b required %b", j, dout[2], e2); end
    end
  endtask

  task automatic test_reset_mid();
    logic ed;
    cfg_write(0, 200, 0);
    din[0] = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (dout !== '0)         begin errors++; $display("FAIL rstmid_dout k=%0d: %b required 0", k, dout); end
      checks++; if (busy !== '0)         begin errors++; $display("FAIL rstmid_busy k=%0d: %b required 0", k, busy); end
      checks++; if (cfg_ready !== 1'b0)  begin errors++; $display("FAIL rstmid_ready k=%0d: %b required 0", k, cfg_ready); end
      checks++; if (glitch_cnt !== '0)   begin errors++; $display("FAIL rstmid_glitch k=%0d: %h required 0", k, glitch_cnt); end
    end
    rst = 1'b0;
    #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after: %b required 1", cfg_ready); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      ed = (k == 3);
      checks++; if (dout[0] !== ed) begin errors++; $display("FAIL rstmid_default_rise k=%0d: %b required %b", k, dout[0], ed); end
    end
    din = '0;
    repeat (5) tick();
  endtask

  task automatic test_random_zero_delay();
    for (int c = 0; c < NCH; c++) begin m_rise[c] = 0; m_fall[c] = 0; end
    model_start();
    run_random(300, 1'b0);
    model_stop();
  endtask

  task automatic test_random_delays();
    cfg_write(0, 3, 1);
    cfg_write(1, 0, 2);
    m_rise[0] = 3; m_fall[0] = 1;
    m_rise[1] = 0; m_fall[1] = 2;
    m_rise[2] = 0; m_fall[2] = 0;
    model_start();
    run_random(400, 1'b1);
    model_stop();
  endtask

  initial begin
    test_reset();
    test_rise_fall();
    test_glitch();
    test_cfg_pending();
    test_cfg_err();
    test_reset_mid();
    test_random_zero_delay();
    test_random_delays();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
